ifu_fetch_ctrl: RTL and testbench

- Parametrised next-generation instruction fetch unit between the PC source and the IF/ID stage.
- Owns the fetch PC and issues sequential prefetch requests over a valid/ready request channel, with up to MAX_OUTSTD requests in flight.
- Buffers returned instructions in an IBUF_DEPTH-entry queue and applies static branch prediction to each returned instruction.
- Accepts execute-stage redirects and discards wrong-path responses. Output to IF/ID is a valid/ready stream.

---
 rtl/ifu_fetch_ctrl_if.sv | 36 +++
 rtl/ifu_fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_ctrl_if.sv
// Signal bundle between the fetch controller and its surroundings: EXU redirect,
// memory request/response channels and the IF/ID output stream.
interface ifu_fetch_ctrl_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   exu_redirect_valid_i;
    logic [PC_WIDTH-1:0]    exu_redirect_pc_i;
    logic                   if_req_valid_o;
    logic                   if_req_ready_i;
    logic [PC_WIDTH-1:0]    if_req_pc_o;
    logic                   if_resp_valid_i;
    logic                   if_resp_ready_o;
    logic                   if_resp_err_i;
    logic [INSTR_WIDTH-1:0] if_resp_instr_i;
    logic                   ifu_o_valid_o;
    logic                   ifu_o_ready_i;
    logic [INSTR_WIDTH-1:0] ifu_o_instr_o;
    logic [PC_WIDTH-1:0]    ifu_o_pc_o;
    logic                   ifu_o_prdt_taken_o;
    logic                   ifu_o_err_o;

    modport master (
        input  exu_redirect_valid_i, exu_redirect_pc_i, if_req_ready_i,
               if_resp_valid_i, if_resp_err_i, if_resp_instr_i, ifu_o_ready_i,
        output if_req_valid_o, if_req_pc_o, if_resp_ready_o, ifu_o_valid_o,
               ifu_o_instr_o, ifu_o_pc_o, ifu_o_prdt_taken_o, ifu_o_err_o
    );

    modport slave (
        output exu_redirect_valid_i, exu_redirect_pc_i, if_req_ready_i,
               if_resp_valid_i, if_resp_err_i, if_resp_instr_i, ifu_o_ready_i,
        input  if_req_valid_o, if_req_pc_o, if_resp_ready_o, ifu_o_valid_o,
               ifu_o_instr_o, ifu_o_pc_o, ifu_o_prdt_taken_o, ifu_o_err_o
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: sequential prefetch with credit-limited requests,
// in-order response tracking, static branch prediction and an output instruction queue.
module ifu_fetch_ctrl #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                  IBUF_DEPTH  = 4,
    parameter int                  MAX_OUTSTD  = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    ifu_fetch_ctrl_if.master bus
);
    localparam int AW = $clog2(IBUF_DEPTH);
    localparam int OW = $clog2(MAX_OUTSTD + 1);

    typedef logic [PC_WIDTH-1:0]    pc_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    function automatic pc_t sext32(input logic [31:0] v);
        return PC_WIDTH'($signed(v));
    endfunction

    // Returns {taken, target}; target is only meaningful when taken.
    function automatic logic [PC_WIDTH:0] predict(input instr_t instr, input pc_t pc);
        logic [31:0] imm_j;
        logic [31:0] imm_b;
        logic [31:0] imm_i;
        logic        taken;
        pc_t         target;
        imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_i = {{21{instr[31]}}, instr[30:20]};
        case (instr[6:0])
            7'b1101111: begin taken = 1'b1;                      target = pc + sext32(imm_j); end
            7'b1100011: begin taken = instr[31];                 target = pc + sext32(imm_b); end
            7'b1100111: begin taken = (instr[19:15] == 5'd0);    target = sext32({imm_i[31:1], 1'b0}); end
            default:    begin taken = 1'b0;                      target = pc; end
        endcase
        return {taken, target};
    endfunction

    pc_t            fetch_pc_q, fetch_pc_d;
    logic           req_valid_q, req_valid_d;
    logic [OW-1:0]  outstd_q, outstd_d;
    logic [OW-1:0]  drop_q, drop_d;
    pc_t            trk_q [MAX_OUTSTD];
    pc_t            trk_d [MAX_OUTSTD];
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
    instr_t         q_instr_q [IBUF_DEPTH];
    instr_t         q_instr_d [IBUF_DEPTH];
    pc_t            q_pc_q [IBUF_DEPTH];
    pc_t            q_pc_d [IBUF_DEPTH];
    logic [IBUF_DEPTH-1:0] q_err_q, q_err_d, q_tkn_q, q_tkn_d;

    logic            exu_s, req_fire_s, resp_fire_s, drop_now_s, pop_s, push_s;
    logic            pred_taken_s, pred_redir_s;
    logic [PC_WIDTH:0] pred_s;
    logic [OW-1:0]   trk_idx_s;
    logic [31:0]     credit_s;

    assign exu_s        = bus.exu_redirect_valid_i;
    assign req_fire_s   = req_valid_q & bus.if_req_ready_i;
    assign resp_fire_s  = bus.if_resp_valid_i;
    assign drop_now_s   = resp_fire_s & (drop_q != {OW{1'b0}});
    assign pop_s        = (wr_ptr_q != rd_ptr_q) & bus.ifu_o_ready_i;
    assign push_s       = resp_fire_s & ~drop_now_s & ~exu_s;
    assign pred_s       = predict(bus.if_resp_instr_i, trk_q[0]);
    assign pred_taken_s = pred_s[PC_WIDTH] & ~bus.if_resp_err_i;
    assign pred_redir_s = push_s & pred_taken_s;

    // Fetch PC, credit counters and queue pointers for the next cycle.
    always_comb begin
        outstd_d = outstd_q + OW'(req_fire_s) - OW'(resp_fire_s);
        if (exu_s) begin
            fetch_pc_d = bus.exu_redirect_pc_i;
        end else if (pred_redir_s) begin
            fetch_pc_d = pred_s[PC_WIDTH-1:0];
        end else if (req_fire_s) begin
            fetch_pc_d = fetch_pc_q + pc_t'(32'd4);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        // Every request still in flight after a redirect is on the wrong path.
        if (exu_s || pred_redir_s) begin
            drop_d = outstd_d;
        end else if (drop_now_s) begin
            drop_d = drop_q - OW'(1'b1);
        end else begin
            drop_d = drop_q;
        end
        if (exu_s) begin
            wr_ptr_d = {(AW+1){1'b0}};
            rd_ptr_d = {(AW+1){1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(push_s);
            rd_ptr_d = rd_ptr_q + (AW+1)'(pop_s);
        end
        count_d     = wr_ptr_d - rd_ptr_d;
        credit_s    = 32'(count_d) + 32'(outstd_d) - 32'(drop_d);
        req_valid_d = (32'(outstd_d) < 32'(MAX_OUTSTD)) && (credit_s < 32'(IBUF_DEPTH));
    end

    // In-order PC tracker (head at index 0) and queue storage writes.
    always_comb begin
        trk_d     = trk_q;
        trk_idx_s = outstd_q - OW'(resp_fire_s);
        if (resp_fire_s) begin
            for (int i = 0; i < MAX_OUTSTD - 1; i++) trk_d[i] = trk_q[i+1];
        end else begin
            trk_d = trk_q;
        end
        if (req_fire_s) begin
            for (int i = 0; i < MAX_OUTSTD; i++) begin
                if (OW'(i) == trk_idx_s) trk_d[i] = fetch_pc_q;
            end
        end else begin
            trk_idx_s = trk_idx_s;
        end
        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        q_err_d   = q_err_q;
        q_tkn_d   = q_tkn_q;
        if (push_s) begin
            q_instr_d[wr_ptr_q[AW-1:0]] = bus.if_resp_instr_i;
            q_pc_d[wr_ptr_q[AW-1:0]]    = trk_q[0];
            q_err_d[wr_ptr_q[AW-1:0]]   = bus.if_resp_err_i;
            q_tkn_d[wr_ptr_q[AW-1:0]]   = pred_taken_s;
        end else begin
            q_err_d = q_err_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            outstd_q    <= {OW{1'b0}};
            drop_q      <= {OW{1'b0}};
            trk_q       <= '{default: '0};
            wr_ptr_q    <= {(AW+1){1'b0}};
            rd_ptr_q    <= {(AW+1){1'b0}};
            q_instr_q   <= '{default: '0};
            q_pc_q      <= '{default: '0};
            q_err_q     <= {IBUF_DEPTH{1'b0}};
            q_tkn_q     <= {IBUF_DEPTH{1'b0}};
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
            outstd_q    <= outstd_d;
            drop_q      <= drop_d;
            trk_q       <= trk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            q_instr_q   <= q_instr_d;
            q_pc_q      <= q_pc_d;
            q_err_q     <= q_err_d;
            q_tkn_q     <= q_tkn_d;
        end
    end

    assign bus.if_req_valid_o     = req_valid_q;
    assign bus.if_req_pc_o        = fetch_pc_q;
    assign bus.if_resp_ready_o    = 1'b1;
    assign bus.ifu_o_valid_o      = (wr_ptr_q != rd_ptr_q);
    assign bus.ifu_o_instr_o      = q_instr_q[rd_ptr_q[AW-1:0]];
    assign bus.ifu_o_pc_o         = q_pc_q[rd_ptr_q[AW-1:0]];
    assign bus.ifu_o_prdt_taken_o = q_tkn_q[rd_ptr_q[AW-1:0]];
    assign bus.ifu_o_err_o        = q_err_q[rd_ptr_q[AW-1:0]];
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Random-stimulus bench: a program model walks the expected instruction path and a
// monitor compares every delivered instruction against it.
module tb_ifu_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int NCYC = 4000;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic        taken;
        logic [31:0] target;
    } word_t;
    typedef struct packed { logic [31:0] pc; word_t w; } exp_t;
    typedef struct packed { logic [31:0] pc; int due; } pend_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    int pops = 0;

    ifu_fetch_ctrl_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) ifb ();

    ifu_fetch_ctrl #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RST_PC),
        .IBUF_DEPTH(4), .MAX_OUTSTD(2)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] hsh(input logic [31:0] pc);
        logic [31:0] h;
        h = pc ^ 32'h5BD1_E995;
        h = h * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        h = h * 32'h85EB_CA6B;
        h = h ^ (h >> 13);
        return h;
    endfunction

    // Program memory: each word is built from a chosen kind and offset, so the
    // expected prediction comes from the construction, not from decoding.
    function automatic word_t gen(input logic [31:0] pc);
        logic [31:0] h, offv, imm;
        logic [4:0]  rs1;
        word_t w;
        h = hsh(pc);
        offv = (32'(h[10:4]) - 32'd64) << 2;
        w.err = (h[31:28] == 4'hF);
        w.taken = 1'b0;
        w.target = pc + 32'd4;
        case (h[3:0])
            4'd0: begin
                w.instr = {offv[20], offv[10:1], offv[11], offv[19:12], 5'd1, 7'b1101111};
                w.taken = 1'b1; w.target = pc + offv;
            end
            4'd1, 4'd2: begin
                w.instr = {offv[12], offv[10:5], h[20:16], h[25:21], 3'b000, offv[4:1], offv[11], 7'b1100011};
                w.taken = offv[31]; w.target = pc + offv;
            end
            4'd3: begin
                rs1 = h[11] ? 5'd0 : h[16:12];
                imm = {{20{h[27]}}, h[27:18], 1'b0, h[17]};
                w.instr = {imm[11:0], rs1, 3'b000, 5'd1, 7'b1100111};
                w.taken = (rs1 == 5'd0); w.target = {imm[31:1], 1'b0};
            end
            default: w.instr = {h[31:20], h[19:15], 3'b000, h[11:7], 7'b0010011};
        endcase
        if (w.err) w.taken = 1'b0;
        if (!w.taken) w.target = pc + 32'd4;
        return w;
    endfunction

    // Scoreboard monitor: expected path entries are queued ahead and popped per delivery.
    exp_t exp_q[$];
    logic [31:0] gen_pc;
    initial begin
        exp_t e;
        gen_pc = RST_PC;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge clk);
            while (exp_q.size() < 4) begin
                e.pc = gen_pc;
                e.w = gen(gen_pc);
                exp_q.push_back(e);
                gen_pc = e.w.target;
            end
            if (ifb.exu_redirect_valid_i) begin
                exp_q.delete();
                gen_pc = ifb.exu_redirect_pc_i;
            end else if (ifb.ifu_o_valid_o && ifb.ifu_o_ready_i) begin
                e = exp_q.pop_front();
                chk("out_pc", ifb.ifu_o_pc_o, e.pc);
                chk("out_instr", ifb.ifu_o_instr_o, e.w.instr);
                chk("out_err", 32'(ifb.ifu_o_err_o), 32'(e.w.err));
                chk("out_taken", 32'(ifb.ifu_o_prdt_taken_o), 32'(e.w.taken));
                pops++;
            end
        end
    end

    // Stimulus: random handshakes, in-order memory with 1..3 cycle latency, random EXU redirects.
    initial begin
        pend_t pend[$];
        pend_t p;
        word_t w;
        int last_due;
        logic prev_v, prev_r, seen_first, stall;
        ifb.exu_redirect_valid_i = 1'b0;
        ifb.exu_redirect_pc_i    = 32'h0;
        ifb.if_req_ready_i       = 1'b0;
        ifb.if_resp_valid_i      = 1'b0;
        ifb.if_resp_err_i        = 1'b0;
        ifb.if_resp_instr_i      = 32'h0;
        ifb.ifu_o_ready_i        = 1'b0;
        last_due = 0; prev_v = 1'b0; prev_r = 1'b0; seen_first = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(ifb.if_req_valid_o), 32'd0);
        chk("rst_req_pc", ifb.if_req_pc_o, RST_PC);
        chk("rst_o_valid", 32'(ifb.ifu_o_valid_o), 32'd0);
        chk("rst_o_pc", ifb.ifu_o_pc_o, 32'd0);
        chk("rst_o_instr", ifb.ifu_o_instr_o, 32'd0);
        chk("rst_o_flags", {30'd0, ifb.ifu_o_err_o, ifb.ifu_o_prdt_taken_o}, 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            stall = (c >= 1000 && c < 1030);
            if (prev_v && !prev_r) chk("req_valid_hold", 32'(ifb.if_req_valid_o), 32'd1);
            if (!seen_first && ifb.if_req_valid_o) begin
                chk("first_req_pc", ifb.if_req_pc_o, RST_PC);
                seen_first = 1'b1;
            end
            if (c == 1029) begin
                chk("stall_req_valid", 32'(ifb.if_req_valid_o), 32'd0);
                chk("stall_o_valid", 32'(ifb.ifu_o_valid_o), 32'd1);
            end
            chk("resp_ready", 32'(ifb.if_resp_ready_o), 32'd1);
            ifb.ifu_o_ready_i  = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            ifb.if_req_ready_i = stall ? 1'b1 : ($urandom_range(0, 3) != 0);
            ifb.exu_redirect_valid_i = !stall && (c > 10) && ($urandom_range(0, 39) == 0);
            ifb.exu_redirect_pc_i    = 32'h0000_2000 + 32'($urandom_range(0, 255)) * 32'd4;
            if (pend.size() > 0 && pend[0].due <= c) begin
                p = pend.pop_front();
                w = gen(p.pc);
                ifb.if_resp_valid_i = 1'b1;
                ifb.if_resp_instr_i = w.instr;
                ifb.if_resp_err_i   = w.err;
            end else begin
                ifb.if_resp_valid_i = 1'b0;
                ifb.if_resp_instr_i = $urandom;
                ifb.if_resp_err_i   = 1'b0;
            end
            if (ifb.if_req_valid_o && ifb.if_req_ready_i) begin
                p.pc  = ifb.if_req_pc_o;
                p.due = c + int'($urandom_range(1, 3));
                if (p.due < last_due) p.due = last_due;
                last_due = p.due;
                pend.push_back(p);
            end
            prev_v = ifb.if_req_valid_o;
            prev_r = ifb.if_req_ready_i;
            @(posedge clk);
            #1;
        end
        chk("progress_min_pops", 32'(pops >= 200), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
